// File: rtl/gpio_ram_periph_pkg.sv
// Shared address map, GPIO register offsets and the response-register type.
// Pure declarations; no latency or backpressure of its own.
package gpio_ram_periph_pkg;

   localparam logic [15:0] GPIO_BASE_HI = 16'hF000;
   localparam logic [31:0] RAM_BASE     = 32'h0000_0000;

   localparam logic [11:0] GPIO_OE = 12'h000;
   localparam logic [11:0] GPIO_DO = 12'h004;
   localparam logic [11:0] GPIO_DI = 12'h008;

   typedef enum logic [1:0] {
      TGT_VOID = 2'd0,
      TGT_RAM  = 2'd1,
      TGT_GPIO = 2'd2
   } tgt_e;

   typedef struct packed {
      logic        vld;
      logic [31:0] dat;
   } rsp_t;

   // RAM wins any overlap so a large RAM size never loses words to the GPIO window.
   function automatic tgt_e decode(input logic [31:0] addr, input logic [31:0] ram_bytes);
      if ((addr - RAM_BASE) < ram_bytes) return TGT_RAM;
      if (addr[31:16] == GPIO_BASE_HI)   return TGT_GPIO;
      return TGT_VOID;
   endfunction

endpackage

// File: rtl/gpio_ram_periph_ram.sv
// Byte-writable single-port word RAM; rdata register loads on rd and holds otherwise.
// Read data one edge after rd; writes commit at the edge, never stall.
module periph_ram #(
   parameter int WORDS = 2048
) (
   input  logic        clk,
   input  logic [3:0]  wr,
   input  logic        rd,
   input  logic [15:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata
);

   localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

   logic [31:0]   mem_q [WORDS];
   logic [31:0]   rdata_q;
   logic [AW-1:0] idx;

   // High word-index bits beyond the array size are intentionally dropped (wrap).
   assign idx = addr[AW-1:0];
   wire unused_addr = &{1'b0, addr};

   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (wr[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
      if (rd) rdata_q <= mem_q[idx];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/gpio_ram_periph.sv
// CPU-bus peripheral: address decode, local RAM, GPIO registers and read-response mux.
// Reads: RAM 2 cycles, GPIO/void 1 cycle; no backpressure, every command accepted.
module gpio_ram_periph
   import gpio_ram_periph_pkg::*;
#(
   parameter int LOCAL_RAM_SIZE_KB = 8,
   parameter int NR_GPIOS          = 8
) (
   input  logic                clk,
   input  logic                reset_,
   input  logic                mem_cmd_valid,
   input  logic                mem_cmd_wr,
   input  logic [31:0]         mem_cmd_addr,
   input  logic [31:0]         mem_cmd_wdata,
   input  logic [3:0]          mem_cmd_be,
   output logic                mem_rsp_ready,
   output logic [31:0]         mem_rsp_rdata,
   output logic [NR_GPIOS-1:0] gpio_oe,
   output logic [NR_GPIOS-1:0] gpio_do,
   input  logic [NR_GPIOS-1:0] gpio_di
);

   localparam int          WORDS     = LOCAL_RAM_SIZE_KB * 256;
   localparam logic [31:0] RAM_BYTES = 32'(LOCAL_RAM_SIZE_KB * 1024);

   tgt_e        cmd_tgt;
   logic        cmd_rd_vld;
   logic        cmd_wr_vld;
   logic [11:0] gpio_off;

   assign cmd_tgt    = decode(mem_cmd_addr, RAM_BYTES);
   assign cmd_rd_vld = mem_cmd_valid & ~mem_cmd_wr;
   assign cmd_wr_vld = mem_cmd_valid &  mem_cmd_wr;
   assign gpio_off   = mem_cmd_addr[11:0];

   logic [3:0]  ram_wr;
   logic        ram_rd;
   logic [31:0] ram_rdata;

   assign ram_wr = (cmd_wr_vld && cmd_tgt == TGT_RAM) ? mem_cmd_be : 4'b0000;
   assign ram_rd = cmd_rd_vld && cmd_tgt == TGT_RAM;

   periph_ram #(
      .WORDS (WORDS)
   ) u_ram (
      .clk   (clk),
      .wr    (ram_wr),
      .rd    (ram_rd),
      .addr  (mem_cmd_addr[17:2]),
      .wdata (mem_cmd_wdata),
      .rdata (ram_rdata)
   );

   logic [NR_GPIOS-1:0] oe_q, oe_d;
   logic [NR_GPIOS-1:0] do_q, do_d;
   logic [NR_GPIOS-1:0] di_meta_q, di_sync_q;
   logic [31:0]         gpio_rdat;

   // Byte enables are deliberately ignored for GPIO writes.
   always_comb begin
      oe_d = oe_q;
      do_d = do_q;
      if (cmd_wr_vld && cmd_tgt == TGT_GPIO) begin
         if (gpio_off == GPIO_OE) oe_d = mem_cmd_wdata[NR_GPIOS-1:0];
         if (gpio_off == GPIO_DO) do_d = mem_cmd_wdata[NR_GPIOS-1:0];
      end
   end

   always_comb begin
      gpio_rdat = '0;
      case (gpio_off)
         GPIO_OE: gpio_rdat[NR_GPIOS-1:0] = oe_q;
         GPIO_DO: gpio_rdat[NR_GPIOS-1:0] = do_q;
         GPIO_DI: gpio_rdat[NR_GPIOS-1:0] = di_sync_q;
         default: gpio_rdat = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         oe_q      <= '0;
         do_q      <= '0;
         di_meta_q <= '0;
         di_sync_q <= '0;
      end else begin
         oe_q      <= oe_d;
         do_q      <= do_d;
         di_meta_q <= gpio_di;
         di_sync_q <= di_meta_q;
      end
   end

   assign gpio_oe = oe_q;
   assign gpio_do = do_q;

   logic ram_pend_q, ram_pend_d;
   rsp_t ram_rsp_q, ram_rsp_d;
   rsp_t gpio_rsp_q, gpio_rsp_d;
   logic void_rsp_q, void_rsp_d;

   // RAM reads take one stage for the array read, then the output register.
   always_comb begin
      ram_pend_d     = ram_rd;
      ram_rsp_d.vld  = ram_pend_q;
      ram_rsp_d.dat  = ram_pend_q ? ram_rdata : ram_rsp_q.dat;
      gpio_rsp_d.vld = cmd_rd_vld && cmd_tgt == TGT_GPIO;
      gpio_rsp_d.dat = gpio_rsp_d.vld ? gpio_rdat : gpio_rsp_q.dat;
      void_rsp_d     = cmd_rd_vld && cmd_tgt == TGT_VOID;
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         ram_pend_q <= 1'b0;
         ram_rsp_q  <= '0;
         gpio_rsp_q <= '0;
         void_rsp_q <= 1'b0;
      end else begin
         ram_pend_q <= ram_pend_d;
         ram_rsp_q  <= ram_rsp_d;
         gpio_rsp_q <= gpio_rsp_d;
         void_rsp_q <= void_rsp_d;
      end
   end

   assign mem_rsp_ready = ram_rsp_q.vld | gpio_rsp_q.vld | void_rsp_q;

   always_comb begin
      mem_rsp_rdata = '0;
      if (ram_rsp_q.vld)       mem_rsp_rdata = ram_rsp_q.dat;
      else if (gpio_rsp_q.vld) mem_rsp_rdata = gpio_rsp_q.dat;
   end

endmodule

// File: tb/tb_gpio_ram_periph.sv
// Self-checking bench for gpio_ram_periph: directed scenarios plus a randomized
// command mix checked against a byte-array / register-value reference model.
module tb_gpio_ram_periph;

   localparam int KB    = 8;
   localparam int NG    = 8;
   localparam int WORDS = KB * 256;

   logic          clk = 1'b0;
   logic          reset_ = 1'b0;
   logic          valid = 1'b0;
   logic          wr = 1'b0;
   logic [31:0]   addr = '0;
   logic [31:0]   wdata = '0;
   logic [3:0]    be = '0;
   logic          rsp_rdy;
   logic [31:0]   rsp_dat;
   logic [NG-1:0] oe;
   logic [NG-1:0] dout;
   logic [NG-1:0] di = '0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   gpio_ram_periph #(
      .LOCAL_RAM_SIZE_KB (KB),
      .NR_GPIOS          (NG)
   ) dut (
      .clk           (clk),
      .reset_        (reset_),
      .mem_cmd_valid (valid),
      .mem_cmd_wr    (wr),
      .mem_cmd_addr  (addr),
      .mem_cmd_wdata (wdata),
      .mem_cmd_be    (be),
      .mem_rsp_ready (rsp_rdy),
      .mem_rsp_rdata (rsp_dat),
      .gpio_oe       (oe),
      .gpio_do       (dout),
      .gpio_di       (di)
   );

   // Reference model
   logic [31:0]   m_ram [WORDS];
   logic [NG-1:0] m_oe = '0;
   logic [NG-1:0] m_do = '0;
   logic [NG-1:0] m_di = '0;

   function automatic bit is_ram(input logic [31:0] a);
      return a < 32'(KB * 1024);
   endfunction

   function automatic bit is_gpio(input logic [31:0] a);
      return (a >> 16) == 32'hF000;
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
      int idx;
      int off;
      if (is_ram(a)) begin
         idx = int'((a / 4) % WORDS);
         for (int i = 0; i < 4; i++) if (b[i]) m_ram[idx][8*i +: 8] = d[8*i +: 8];
      end else if (is_gpio(a)) begin
         off = int'(a % 4096);
         if (off == 0) m_oe = d[NG-1:0];
         if (off == 4) m_do = d[NG-1:0];
      end
   endtask

   task automatic model_read(input logic [31:0] a, output int lat, output logic [31:0] d);
      int off;
      d = '0;
      if (is_ram(a)) begin
         lat = 2;
         d = m_ram[int'((a / 4) % WORDS)];
      end else if (is_gpio(a)) begin
         lat = 1;
         off = int'(a % 4096);
         if (off == 0) d = 32'(m_oe);
         else if (off == 4) d = 32'(m_do);
         else if (off == 8) d = 32'(m_di);
      end else begin
         lat = 1;
      end
   endtask

   // Issues one command and watches the response for 4 cycles.
   task automatic do_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b, output int lat, output int pulses,
                         output logic [31:0] data, output logic leak);
      @(negedge clk);
      valid = 1'b1; wr = w; addr = a; wdata = d; be = b;
      lat = 0; pulses = 0; data = '0; leak = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (c == 1) begin
            valid = 1'b0; wr = 1'b0; addr = '0; wdata = '0; be = '0;
         end
         if (rsp_rdy) begin
            pulses++;
            if (lat == 0) begin
               lat = c;
               data = rsp_dat;
            end
         end else if (rsp_dat != 32'h0) begin
            leak = 1'b1;
         end
      end
   endtask

   task automatic set_di(input logic [NG-1:0] v);
      @(negedge clk);
      di = v;
      repeat (3) @(negedge clk);
      m_di = v;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      checks++;
      if (rsp_rdy !== 1'b0 || oe !== '0 || dout !== '0 || rsp_dat !== '0) begin
         failures++;
         $display("FAIL reset_state: rdy=%0b oe=%h do=%h rdata=%h, want all 0", rsp_rdy, oe, dout, rsp_dat);
      end
      reset_ = 1'b1;
      @(negedge clk);
      checks++;
      if (rsp_rdy !== 1'b0) begin
         failures++;
         $display("FAIL reset_release_rdy: rdy=%0b want 0", rsp_rdy);
      end
   endtask

   task automatic test_ram_basic;
      int lat, pulses;
      logic [31:0] data;
      logic leak;
      do_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, lat, pulses, data, leak);
      model_write(32'h10, 32'hDEADBEEF, 4'b1111);
      checks++;
      if (pulses !== 0) begin
         failures++;
         $display("FAIL ram_write_no_rsp: pulses=%0d want 0", pulses);
      end
      do_cmd(1'b0, 32'h10, '0, '0, lat, pulses, data, leak);
      checks++;
      if (lat !== 2 || pulses !== 1 || data !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL ram_read_full: lat=%0d pulses=%0d data=%h, want lat=2 pulses=1 data=deadbeef", lat, pulses, data);
      end
      do_cmd(1'b1, 32'h10, 32'h000000AA, 4'b0001, lat, pulses, data, leak);
      model_write(32'h10, 32'h000000AA, 4'b0001);
      do_cmd(1'b0, 32'h10, '0, '0, lat, pulses, data, leak);
      checks++;
      if (lat !== 2 || data !== 32'hDEADBEAA) begin
         failures++;
         $display("FAIL ram_byte_write: lat=%0d data=%h, want lat=2 data=deadbeaa", lat, data);
      end
      do_cmd(1'b1, 32'h10, 32'h12345678, 4'b0000, lat, pulses, data, leak);
      model_write(32'h10, 32'h12345678, 4'b0000);
      do_cmd(1'b0, 32'h10, '0, '0, lat, pulses, data, leak);
      checks++;
      if (lat !== 2 || data !== 32'hDEADBEAA) begin
         failures++;
         $display("FAIL ram_be_zero: lat=%0d data=%h, want lat=2 data=deadbeaa", lat, data);
      end
      do_cmd(1'b1, 32'h1FFC, 32'hCAFEF00D, 4'b1111, lat, pulses, data, leak);
      model_write(32'h1FFC, 32'hCAFEF00D, 4'b1111);
      do_cmd(1'b0, 32'h1FFC, '0, '0, lat, pulses, data, leak);
      checks++;
      if (lat !== 2 || data !== 32'hCAFEF00D) begin
         failures++;
         $display("FAIL ram_last_word: lat=%0d data=%h, want lat=2 data=cafef00d", lat, data);
      end
   endtask

   task automatic test_gpio;
      int lat, pulses;
      logic [31:0] data;
      logic leak;
      do_cmd(1'b1, 32'hF0000004, 32'h5A, 4'b0000, lat, pulses, data, leak);
      model_write(32'hF0000004, 32'h5A, 4'b0000);
      do_cmd(1'b1, 32'hF0000000, 32'hFF, 4'b0001, lat, pulses, data, leak);
      model_write(32'hF0000000, 32'hFF, 4'b0001);
      checks++;
      if (dout !== 8'h5A || oe !== 8'hFF || pulses !== 0) begin
         failures++;
         $display("FAIL gpio_write: do=%h oe=%h pulses=%0d, want do=5a oe=ff pulses=0", dout, oe, pulses);
      end
      do_cmd(1'b0, 32'hF0000004, '0, '0, lat, pulses, data, leak);
      checks++;
      if (lat !== 1 || pulses !== 1 || data !== 32'h5A) begin
         failures++;
         $display("FAIL gpio_read_do: lat=%0d pulses=%0d data=%h, want lat=1 pulses=1 data=5a", lat, pulses, data);
      end
      set_di(8'h3C);
      do_cmd(1'b0, 32'hF0000008, '0, '0, lat, pulses, data, leak);
      checks++;
      if (lat !== 1 || data !== 32'h3C) begin
         failures++;
         $display("FAIL gpio_read_di: lat=%0d data=%h, want lat=1 data=3c", lat, data);
      end
      do_cmd(1'b1, 32'hF0000008, 32'h00, 4'b1111, lat, pulses, data, leak);
      do_cmd(1'b0, 32'hF0000008, '0, '0, lat, pulses, data, leak);
      checks++;
      if (data !== 32'h3C || oe !== 8'hFF || dout !== 8'h5A) begin
         failures++;
         $display("FAIL gpio_di_readonly: di=%h oe=%h do=%h, want di=3c oe=ff do=5a", data, oe, dout);
      end
      do_cmd(1'b1, 32'hF0000100, 32'h11, 4'b1111, lat, pulses, data, leak);
      do_cmd(1'b0, 32'hF0000100, '0, '0, lat, pulses, data, leak);
      checks++;
      if (lat !== 1 || data !== 32'h0 || oe !== 8'hFF || dout !== 8'h5A) begin
         failures++;
         $display("FAIL gpio_unmapped: lat=%0d data=%h oe=%h do=%h, want lat=1 data=0 oe=ff do=5a", lat, data, oe, dout);
      end
   endtask

   task automatic test_void;
      int lat, pulses;
      logic [31:0] data;
      logic leak;
      do_cmd(1'b0, 32'h40000000, '0, '0, lat, pulses, data, leak);
      checks++;
      if (lat !== 1 || pulses !== 1 || data !== 32'h0 || leak !== 1'b0) begin
         failures++;
         $display("FAIL void_read: lat=%0d pulses=%0d data=%h leak=%0b, want 1/1/0/0", lat, pulses, data, leak);
      end
      do_cmd(1'b0, 32'h2000, '0, '0, lat, pulses, data, leak);
      checks++;
      if (lat !== 1 || data !== 32'h0) begin
         failures++;
         $display("FAIL void_ram_edge: lat=%0d data=%h, want lat=1 data=0", lat, data);
      end
      do_cmd(1'b1, 32'h40000000, 32'hFFFFFFFF, 4'b1111, lat, pulses, data, leak);
      checks++;
      if (pulses !== 0) begin
         failures++;
         $display("FAIL void_write: pulses=%0d want 0", pulses);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] e0, e1;
      int l;
      model_read(32'h10, l, e0);
      model_read(32'h1FFC, l, e1);
      @(negedge clk); valid = 1'b1; wr = 1'b0; addr = 32'h10;
      @(negedge clk); addr = 32'h1FFC;
      @(negedge clk); valid = 1'b0; addr = '0;
      checks++;
      if (rsp_rdy !== 1'b1 || rsp_dat !== e0) begin
         failures++;
         $display("FAIL b2b_ram_first: rdy=%0b data=%h, want 1 %h", rsp_rdy, rsp_dat, e0);
      end
      @(negedge clk);
      checks++;
      if (rsp_rdy !== 1'b1 || rsp_dat !== e1) begin
         failures++;
         $display("FAIL b2b_ram_second: rdy=%0b data=%h, want 1 %h", rsp_rdy, rsp_dat, e1);
      end
      @(negedge clk);
      checks++;
      if (rsp_rdy !== 1'b0) begin
         failures++;
         $display("FAIL b2b_ram_tail: rdy=%0b want 0", rsp_rdy);
      end
      @(negedge clk); valid = 1'b1; addr = 32'hF0000000;
      @(negedge clk); addr = 32'hF0000004;
      checks++;
      if (rsp_rdy !== 1'b1 || rsp_dat !== 32'(m_oe)) begin
         failures++;
         $display("FAIL b2b_gpio_first: rdy=%0b data=%h, want 1 %h", rsp_rdy, rsp_dat, m_oe);
      end
      @(negedge clk); valid = 1'b0; addr = '0;
      checks++;
      if (rsp_rdy !== 1'b1 || rsp_dat !== 32'(m_do)) begin
         failures++;
         $display("FAIL b2b_gpio_second: rdy=%0b data=%h, want 1 %h", rsp_rdy, rsp_dat, m_do);
      end
   endtask

   task automatic test_random;
      int lat, pulses, elat;
      logic [31:0] data, exp, a, d;
      logic [3:0] b;
      logic w, leak;
      logic [31:0] gpio_addrs [5];
      logic [31:0] void_addrs [3];
      gpio_addrs = '{32'hF0000000, 32'hF0000004, 32'hF0000008, 32'hF000000C, 32'hF0000100};
      void_addrs = '{32'h00002000, 32'h40000000, 32'hF0010000};
      for (int i = 0; i < 16; i++) begin
         d = $urandom;
         do_cmd(1'b1, 32'(i * 4), d, 4'b1111, lat, pulses, data, leak);
         model_write(32'(i * 4), d, 4'b1111);
      end
      for (int n = 0; n < 80; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: a = 32'($urandom_range(0, 15) * 4);
            4, 5, 6:    a = gpio_addrs[$urandom_range(0, 4)];
            7:          a = void_addrs[$urandom_range(0, 2)];
            default: begin
               set_di(NG'($urandom));
               a = 32'hF0000008;
            end
         endcase
         w = 1'($urandom_range(0, 1));
         d = $urandom;
         b = 4'($urandom);
         if (w) begin
            do_cmd(1'b1, a, d, b, lat, pulses, data, leak);
            model_write(a, d, b);
            checks++;
            if (pulses !== 0 || oe !== m_oe || dout !== m_do) begin
               failures++;
               $display("FAIL rand_write[%0d] a=%h: pulses=%0d oe=%h do=%h, want 0 %h %h", n, a, pulses, oe, dout, m_oe, m_do);
            end
         end else begin
            model_read(a, elat, exp);
            do_cmd(1'b0, a, '0, '0, lat, pulses, data, leak);
            checks++;
            if (lat !== elat || pulses !== 1 || data !== exp || leak !== 1'b0) begin
               failures++;
               $display("FAIL rand_read[%0d] a=%h: lat=%0d pulses=%0d data=%h leak=%0b, want lat=%0d pulses=1 data=%h leak=0",
                        n, a, lat, pulses, data, leak, elat, exp);
            end
         end
      end
   endtask

   task automatic test_reset_mid_read;
      int lat, pulses, elat;
      logic [31:0] data, exp;
      logic leak;
      do_cmd(1'b1, 32'hF0000000, 32'hA5, 4'b1111, lat, pulses, data, leak);
      do_cmd(1'b1, 32'hF0000004, 32'h3C, 4'b1111, lat, pulses, data, leak);
      @(negedge clk); valid = 1'b1; wr = 1'b0; addr = 32'h10;
      @(posedge clk);
      #2;
      valid = 1'b0; addr = '0; reset_ = 1'b0;
      #1;
      m_oe = '0; m_do = '0;
      checks++;
      if (oe !== '0 || dout !== '0 || rsp_rdy !== 1'b0) begin
         failures++;
         $display("FAIL reset_async: oe=%h do=%h rdy=%0b, want 0 0 0", oe, dout, rsp_rdy);
      end
      @(negedge clk);
      reset_ = 1'b1;
      pulses = 0;
      repeat (4) begin
         @(negedge clk);
         if (rsp_rdy) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         failures++;
         $display("FAIL reset_lost_read: pulses=%0d want 0", pulses);
      end
      model_read(32'h10, elat, exp);
      do_cmd(1'b0, 32'h10, '0, '0, lat, pulses, data, leak);
      checks++;
      if (lat !== elat || data !== exp) begin
         failures++;
         $display("FAIL reset_ram_kept: lat=%0d data=%h, want lat=%0d data=%h", lat, data, elat, exp);
      end
   endtask

   initial begin
      test_reset();
      test_ram_basic();
      test_gpio();
      test_void();
      test_back_to_back();
      test_random();
      test_reset_mid_read();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
